// File: rtl/hazard_pipe_ctrl_if.sv
// hazard_pipe_ctrl_if: ID-stage request and pipeline-control response bundle for the hazard controller.
interface hazard_pipe_ctrl_if #(
    parameter int CTRL_W = 15,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0] ctrl_id;
    logic [REG_W-1:0]  rs_id;
    logic [REG_W-1:0]  rt_id;
    logic [REG_W-1:0]  rd_id;
    logic              rs_eq_rt;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic [1:0]        pc_sel;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [REG_W-1:0]  ex_dst;
    logic [REG_W-1:0]  mem_dst;
    logic [REG_W-1:0]  wb_dst;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ctrl_id, rs_id, rt_id, rd_id, rs_eq_rt,
        input  pc_write, ifid_write, ifid_flush, pc_sel, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_dst, mem_dst, wb_dst, stall_cnt
    );

    modport slave (
        input  ctrl_id, rs_id, rt_id, rd_id, rs_eq_rt,
        output pc_write, ifid_write, ifid_flush, pc_sel, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_dst, mem_dst, wb_dst, stall_cnt
    );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: 5-stage MIPS control pipeline with stall-based RAW resolution and ID-stage branch/jump flush.
module hazard_pipe_ctrl #(
    parameter int CTRL_W = 15,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    hazard_pipe_ctrl_if.slave bus
);
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [REG_W-1:0]  ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [REG_W-1:0]  dst_id;
    logic              use_rs, use_rt, hz_ex, hz_mem, stall, taken;

    always_comb begin
        dst_id      = bus.ctrl_id[3] ? (bus.ctrl_id[0] ? bus.rd_id : bus.rt_id) : '0;
        use_rs      = ~bus.ctrl_id[7];
        use_rt      = bus.ctrl_id[0] | bus.ctrl_id[4] | bus.ctrl_id[13];
        // $0 is hard-wired, so a zero destination never creates a dependence
        hz_ex       = ex_ctrl_q[3] & (ex_dst_q != '0) &
                      ((use_rs & (bus.rs_id == ex_dst_q)) | (use_rt & (bus.rt_id == ex_dst_q)));
        hz_mem      = mem_ctrl_q[3] & (mem_dst_q != '0) &
                      ((use_rs & (bus.rs_id == mem_dst_q)) | (use_rt & (bus.rt_id == mem_dst_q)));
        stall       = hz_ex | hz_mem;
        taken       = ~stall & ((bus.ctrl_id[5] & bus.rs_eq_rt) | (bus.ctrl_id[6] & ~bus.rs_eq_rt));
        ex_ctrl_d   = stall ? '0 : bus.ctrl_id;
        ex_dst_d    = stall ? '0 : dst_id;
        mem_ctrl_d  = ex_ctrl_q;
        mem_dst_d   = ex_dst_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_dst_d    = mem_dst_q;
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl_q   <= '0;
            mem_ctrl_q  <= '0;
            wb_ctrl_q   <= '0;
            ex_dst_q    <= '0;
            mem_dst_q   <= '0;
            wb_dst_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            mem_ctrl_q  <= mem_ctrl_d;
            wb_ctrl_q   <= wb_ctrl_d;
            ex_dst_q    <= ex_dst_d;
            mem_dst_q   <= mem_dst_d;
            wb_dst_q    <= wb_dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_write   = ~stall;
    assign bus.ifid_write = ~stall;
    assign bus.ifid_flush = ~stall & (bus.ctrl_id[7] | taken);
    assign bus.pc_sel     = stall ? 2'b00 : bus.ctrl_id[7] ? 2'b10 : taken ? 2'b01 : 2'b00;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.mem_ctrl   = mem_ctrl_q;
    assign bus.wb_ctrl    = wb_ctrl_q;
    assign bus.ex_dst     = ex_dst_q;
    assign bus.mem_dst    = mem_dst_q;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: directed scoreboard bench; stimulus queues expected values, a negedge monitor compares them.
module tb_hazard_pipe_ctrl;
    localparam logic [14:0] NOP  = 15'h0000;
    localparam logic [14:0] ADDI = 15'h440A;
    localparam logic [14:0] ADD  = 15'h4209;
    localparam logic [14:0] SUB  = 15'h4209;
    localparam logic [14:0] LW   = 15'h400E;
    localparam logic [14:0] SW   = 15'h4012;
    localparam logic [14:0] BEQ  = 15'h6020;
    localparam logic [14:0] BNE  = 15'h6040;
    localparam logic [14:0] JMP  = 15'h4080;

    typedef enum int {PCW, IFW, FLS, PSL, EXC, MMC, WBC, EXD, MMD, WBD, CNT} sig_e;
    typedef struct {
        sig_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hazard_pipe_ctrl_if #(.CNT_W(4)) bus ();
    hazard_pipe_ctrl #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] probe(sig_e s);
        case (s)
            PCW:     return 32'(bus.pc_write);
            IFW:     return 32'(bus.ifid_write);
            FLS:     return 32'(bus.ifid_flush);
            PSL:     return 32'(bus.pc_sel);
            EXC:     return 32'(bus.ex_ctrl);
            MMC:     return 32'(bus.mem_ctrl);
            WBC:     return 32'(bus.wb_ctrl);
            EXD:     return 32'(bus.ex_dst);
            MMD:     return 32'(bus.mem_dst);
            WBD:     return 32'(bus.wb_dst);
            default: return 32'(bus.stall_cnt);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = probe(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic step(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic eq);
        @(posedge clk);
        #1;
        bus.ctrl_id  = c;
        bus.rs_id    = rs;
        bus.rt_id    = rt;
        bus.rd_id    = rd;
        bus.rs_eq_rt = eq;
    endtask

    task automatic expect_v(input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = s;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ctrl_id  = ADDI;
        bus.rs_id    = 5'd1;
        bus.rt_id    = 5'd2;
        bus.rd_id    = 5'd0;
        bus.rs_eq_rt = 1'b0;
        // reset held two edges with ADDI presented
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_v(EXC, 0, "rst_ex_ctrl");
        expect_v(MMC, 0, "rst_mem_ctrl");
        expect_v(WBC, 0, "rst_wb_ctrl");
        expect_v(CNT, 0, "rst_stall_cnt");
        expect_v(PCW, 1, "rst_pc_write");
        step(NOP, 0, 0, 0, 0);
        expect_v(EXC, 32'h440A, "addi_ex_ctrl");
        expect_v(EXD, 2, "addi_ex_dst");
        step(NOP, 0, 0, 0, 0);
        expect_v(MMC, 32'h440A, "addi_mem_ctrl");
        expect_v(MMD, 2, "addi_mem_dst");
        step(NOP, 0, 0, 0, 0);
        expect_v(WBC, 32'h440A, "addi_wb_ctrl");
        expect_v(WBD, 2, "addi_wb_dst");
        // ADD $3 then dependent SUB
        step(ADD, 1, 2, 3, 0);
        expect_v(PCW, 1, "add_pc_write");
        step(SUB, 3, 4, 6, 0);
        expect_v(PCW, 0, "sub_stall1_pc_write");
        expect_v(IFW, 0, "sub_stall1_ifid_write");
        expect_v(EXC, 32'h4209, "add_ex_ctrl");
        expect_v(EXD, 3, "add_ex_dst");
        expect_v(CNT, 0, "sub_stall1_cnt");
        step(SUB, 3, 4, 6, 0);
        expect_v(PCW, 0, "sub_stall2_pc_write");
        expect_v(EXC, 0, "sub_bubble1");
        expect_v(CNT, 1, "sub_stall2_cnt");
        step(SUB, 3, 4, 6, 0);
        expect_v(PCW, 1, "sub_go_pc_write");
        expect_v(EXC, 0, "sub_bubble2");
        expect_v(CNT, 2, "sub_go_cnt");
        step(NOP, 0, 0, 0, 0);
        expect_v(EXC, 32'h4209, "sub_ex_ctrl");
        expect_v(EXD, 6, "sub_ex_dst");
        // LW $5 reaching MEM while SW rt=$5 in ID
        step(LW, 1, 5, 0, 0);
        expect_v(PCW, 1, "lw_pc_write");
        step(NOP, 0, 0, 0, 0);
        expect_v(EXD, 5, "lw_ex_dst");
        step(SW, 1, 5, 0, 0);
        expect_v(PCW, 0, "sw_stall_pc_write");
        expect_v(CNT, 2, "sw_stall_cnt");
        step(SW, 1, 5, 0, 0);
        expect_v(PCW, 1, "sw_go_pc_write");
        expect_v(CNT, 3, "sw_go_cnt");
        expect_v(EXC, 0, "sw_bubble");
        // ADD $0 in EX, consumer reading $0
        step(ADD, 1, 2, 0, 0);
        expect_v(EXC, 32'h4012, "sw_ex_ctrl");
        step(SUB, 0, 0, 7, 0);
        expect_v(PCW, 1, "r0_no_stall");
        expect_v(EXD, 0, "add_r0_ex_dst");
        expect_v(CNT, 3, "r0_cnt");
        // branches with no hazard
        step(BEQ, 1, 2, 0, 1);
        expect_v(PSL, 1, "beq_taken_pc_sel");
        expect_v(FLS, 1, "beq_taken_flush");
        step(BNE, 1, 2, 0, 1);
        expect_v(PSL, 0, "bne_nt_pc_sel");
        expect_v(FLS, 0, "bne_nt_flush");
        step(BNE, 1, 2, 0, 0);
        expect_v(PSL, 1, "bne_taken_pc_sel");
        expect_v(FLS, 1, "bne_taken_flush");
        // BEQ on $4 behind ADDI $4: stall wins over flush
        step(ADDI, 1, 4, 0, 0);
        expect_v(FLS, 0, "addi4_flush");
        step(BEQ, 4, 1, 0, 1);
        expect_v(FLS, 0, "beq_stall1_flush");
        expect_v(PSL, 0, "beq_stall1_pc_sel");
        expect_v(PCW, 0, "beq_stall1_pc_write");
        step(BEQ, 4, 1, 0, 1);
        expect_v(FLS, 0, "beq_stall2_flush");
        expect_v(PSL, 0, "beq_stall2_pc_sel");
        expect_v(CNT, 4, "beq_stall2_cnt");
        step(BEQ, 4, 1, 0, 1);
        expect_v(FLS, 1, "beq_go_flush");
        expect_v(PSL, 1, "beq_go_pc_sel");
        expect_v(CNT, 5, "beq_go_cnt");
        // self-dependent ADDI chain: stalls two of every three cycles
        for (int i = 0; i < 25; i++) step(ADDI, 4, 4, 0, 0);
        expect_v(PCW, 1, "chain_go");
        expect_v(CNT, 15, "sat_cnt_a");
        step(ADDI, 4, 4, 0, 0);
        expect_v(PCW, 0, "chain_stall");
        expect_v(CNT, 15, "sat_cnt_b");
        step(ADDI, 4, 4, 0, 0);
        expect_v(CNT, 15, "sat_cnt_hold");
        step(JMP, 0, 0, 0, 0);
        expect_v(PSL, 2, "j_pc_sel");
        expect_v(FLS, 1, "j_flush");
        expect_v(CNT, 15, "j_cnt");
        // reset in the middle of a stall drops it
        step(ADDI, 1, 4, 0, 0);
        step(BEQ, 4, 1, 0, 1);
        expect_v(FLS, 0, "pre_rst_flush");
        step(BEQ, 4, 1, 0, 1);
        rst_n = 1'b0;
        step(BEQ, 4, 1, 0, 1);
        rst_n = 1'b1;
        expect_v(FLS, 1, "post_rst_flush");
        expect_v(PSL, 1, "post_rst_pc_sel");
        expect_v(CNT, 0, "post_rst_cnt");
        expect_v(MMC, 0, "post_rst_mem_ctrl");
        @(posedge clk);
        #6;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
